// File: rtl/spi_v3_arb_pkg.sv
// Shared helpers and types for the tagged SPI return-path arbiter.
// Build option SPI_V3_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package spi_v3_arb_pkg;

    localparam int default_nbits      = 4;
    localparam int default_num_inputs = 2;

    // Tag width: at least one bit, even for a single source.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int default_addr_nbits = addr_w(default_num_inputs);

    // Tagged message layout for the default configuration; the top re-declares it with its own widths.
    typedef struct packed {
        logic [default_addr_nbits-1:0] addr;
        logic [default_nbits-1:0]      payload;
    } tagged_msg_t;

endpackage

// File: rtl/spi_v3_rr_arbiter.sv
// Request arbiter: round-robin from a rotating pointer, or fixed lowest-index priority
// when SPI_V3_ARB_FIXED_PRIO_EN is defined (pointer not built in that case).
module spi_v3_rr_arbiter
    import spi_v3_arb_pkg::*;
#(
    parameter int num_inputs = 2,
    parameter int idx_w      = addr_w(num_inputs)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [num_inputs-1:0] req,
    input  logic                  en,
    output logic [num_inputs-1:0] grant,
    output logic [idx_w-1:0]      grant_idx
);

    logic found;

`ifdef SPI_V3_ARB_FIXED_PRIO_EN

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < num_inputs; k++) begin
            if (!found && req[k]) begin
                found     = 1'b1;
                grant_idx = idx_w'(k);
            end
        end
    end

`else

    localparam logic [idx_w:0]   n_ext = (idx_w+1)'(num_inputs);
    localparam logic [idx_w-1:0] last  = idx_w'(num_inputs - 1);

    logic [idx_w-1:0] ptr;
    logic [idx_w:0]   cand;

    // NOTE: every output of this block gets a default first; a missed path would infer a latch.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < num_inputs; k++) begin
            cand = {1'b0, ptr} + (idx_w+1)'(k);
            if (cand >= n_ext) cand = cand - n_ext;
            if (!found && req[cand[idx_w-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[idx_w-1:0];
            end
        end
    end

    // The pointer only moves on an actual transfer: winner present and output stage free.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (grant_idx == last) ? '0 : grant_idx + 1'b1;
        end
    end

`endif

    always_comb begin
        grant = '0;
        if (found) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/spi_v3_arbiter_tagged.sv
// N:1 return-path mux with source-index tag and a 1-entry registered output stage.
// SPI_V3_ARB_FIXED_PRIO_EN switches the arbiter from round-robin to fixed priority.
module spi_v3_arbiter_tagged
    import spi_v3_arb_pkg::*;
#(
    parameter int nbits      = 4,
    parameter int num_inputs = 2,
    parameter int addr_nbits = addr_w(num_inputs)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [nbits-1:0]            recv_msg [0:num_inputs-1],
    input  logic [num_inputs-1:0]       recv_val,
    output logic [num_inputs-1:0]       recv_rdy,
    output logic [addr_nbits+nbits-1:0] send_msg,
    output logic                        send_val,
    input  logic                        send_rdy
);

    localparam int idx_w = addr_w(num_inputs);

    typedef struct packed {
        logic [addr_nbits-1:0] addr;
        logic [nbits-1:0]      payload;
    } msg_t;

    logic [num_inputs-1:0] grant;
    logic [idx_w-1:0]      grant_idx;
    logic                  buf_free;
    logic                  load;
    msg_t                  next_msg;

    // Free when empty or draining this cycle; never feeds send_val combinationally.
    assign buf_free = !send_val | send_rdy;

    spi_v3_rr_arbiter #(
        .num_inputs (num_inputs),
        .idx_w      (idx_w)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (recv_val),
        .en        (buf_free & !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign recv_rdy = reset ? '0 : (grant & {num_inputs{buf_free}});
    assign load     = |(recv_val & recv_rdy);

    always_comb begin
        next_msg.addr    = addr_nbits'(grant_idx);
        next_msg.payload = recv_msg[grant_idx];
    end

    // A new load takes priority over a drain, giving one message per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            send_val <= 1'b0;
            send_msg <= '0;
        end else if (load) begin
            send_val <= 1'b1;
            send_msg <= next_msg;
        end else if (send_rdy) begin
            send_val <= 1'b0;
        end
    end

endmodule
